// File: rtl/pixel_color_histogram.sv
// Per-channel qualifying-pixel counters for one picture, followed by a sequential
// scan that picks the dominant channel (lowest index wins ties) and its count.
module pixel_color_histogram #(
  parameter int NCH = 3,
  parameter int CW  = 15,
  localparam int IW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_valid,
  input  logic [NCH-1:0]    pix_ch_en,
  output logic [NCH*CW-1:0] cnt_flat,
  output logic [NCH-1:0]    sat_flags,
  output logic              busy,
  output logic              result_valid,
  output logic [IW-1:0]     dom_idx,
  output logic [NCH-1:0]    dom_onehot,
  output logic [CW-1:0]     dividend
);

  typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg [NCH];
  logic              sat_reg [NCH];
  logic [IW-1:0]     scan_idx_reg;
  logic [IW-1:0]     best_idx_reg, best_idx_next;
  logic [IW-1:0]     dom_idx_reg;
  logic [NCH-1:0]    dom_onehot_reg, onehot_next;
  logic [CW-1:0]     dividend_reg;
  logic              count_en;
  logic              scan_last;

  assign count_en  = (state_reg == COUNT) && pix_valid && !frame_start;
  assign scan_last = (scan_idx_reg == IW'(NCH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (frame_start) begin
      state_next = COUNT;
    end else begin
      case (state_reg)
        COUNT:   if (frame_end) state_next = SCAN;
        SCAN:    if (scan_last) state_next = DONE;
        default: state_next = state_reg;
      endcase
    end
  end

  // Saturating counters; the sticky flag records an increment attempted at full scale.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
          sat_reg[gi] <= 1'b0;
        end else if (frame_start) begin
          cnt_reg[gi] <= '0;
          sat_reg[gi] <= 1'b0;
        end else if (count_en && pix_ch_en[gi]) begin
          if (cnt_reg[gi] == {CW{1'b1}}) sat_reg[gi] <= 1'b1;
          else                           cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
      assign cnt_flat[gi*CW +: CW] = cnt_reg[gi];
      assign sat_flags[gi]         = sat_reg[gi];
    end
  endgenerate

  // Strict greater-than keeps the earlier channel on ties.
  always_comb begin
    best_idx_next = best_idx_reg;
    if (cnt_reg[scan_idx_reg] > cnt_reg[best_idx_reg]) best_idx_next = scan_idx_reg;
    onehot_next = '0;
    for (int k = 0; k < NCH; k++) onehot_next[k] = (best_idx_next == IW'(k));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx_reg   <= '0;
      best_idx_reg   <= '0;
      dom_idx_reg    <= '0;
      dom_onehot_reg <= '0;
      dividend_reg   <= '0;
    end else if (frame_start) begin
      scan_idx_reg   <= '0;
      best_idx_reg   <= '0;
      dom_idx_reg    <= '0;
      dom_onehot_reg <= '0;
      dividend_reg   <= '0;
    end else begin
      case (state_reg)
        COUNT: begin
          if (frame_end) begin
            scan_idx_reg <= IW'(1);
            best_idx_reg <= '0;
          end
        end
        SCAN: begin
          best_idx_reg <= best_idx_next;
          scan_idx_reg <= scan_idx_reg + 1'b1;
          if (scan_last) begin
            dom_idx_reg    <= best_idx_next;
            dom_onehot_reg <= onehot_next;
            dividend_reg   <= cnt_reg[best_idx_next];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state_reg == COUNT) || (state_reg == SCAN);
  assign result_valid = (state_reg == DONE);
  assign dom_idx      = dom_idx_reg;
  assign dom_onehot   = dom_onehot_reg;
  assign dividend     = dividend_reg;

endmodule

// File: tb/tb_pixel_color_histogram.sv
// Randomized and directed bench for pixel_color_histogram: three instances
// (3x15, 3x4, 5x8) share stimulus and are compared against an array-based model.
module tb_pixel_color_histogram;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_start = 1'b0;
  logic       frame_end = 1'b0;
  logic       pix_valid = 1'b0;
  logic [4:0] pix_ch_en = '0;

  always #5 clk = ~clk;

  logic [44:0] a_flat; logic [2:0] a_sat; logic a_busy, a_rv; logic [1:0] a_dom; logic [2:0] a_oh; logic [14:0] a_div;
  logic [11:0] b_flat; logic [2:0] b_sat; logic b_busy, b_rv; logic [1:0] b_dom; logic [2:0] b_oh; logic [3:0]  b_div;
  logic [39:0] c_flat; logic [4:0] c_sat; logic c_busy, c_rv; logic [2:0] c_dom; logic [4:0] c_oh; logic [7:0]  c_div;

  pixel_color_histogram #(.NCH(3), .CW(15)) u_a (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_ch_en(pix_ch_en[2:0]), .cnt_flat(a_flat), .sat_flags(a_sat),
    .busy(a_busy), .result_valid(a_rv), .dom_idx(a_dom), .dom_onehot(a_oh), .dividend(a_div));
  pixel_color_histogram #(.NCH(3), .CW(4)) u_b (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_ch_en(pix_ch_en[2:0]), .cnt_flat(b_flat), .sat_flags(b_sat),
    .busy(b_busy), .result_valid(b_rv), .dom_idx(b_dom), .dom_onehot(b_oh), .dividend(b_div));
  pixel_color_histogram #(.NCH(5), .CW(8)) u_c (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_ch_en(pix_ch_en), .cnt_flat(c_flat), .sat_flags(c_sat),
    .busy(c_busy), .result_valid(c_rv), .dom_idx(c_dom), .dom_onehot(c_oh), .dividend(c_div));

  logic [63:0] o_flat [3], o_sat [3], o_dom [3], o_oh [3], o_div [3], o_busy [3], o_rv [3];
  assign o_flat[0] = 64'(a_flat); assign o_flat[1] = 64'(b_flat); assign o_flat[2] = 64'(c_flat);
  assign o_sat[0]  = 64'(a_sat);  assign o_sat[1]  = 64'(b_sat);  assign o_sat[2]  = 64'(c_sat);
  assign o_dom[0]  = 64'(a_dom);  assign o_dom[1]  = 64'(b_dom);  assign o_dom[2]  = 64'(c_dom);
  assign o_oh[0]   = 64'(a_oh);   assign o_oh[1]   = 64'(b_oh);   assign o_oh[2]   = 64'(c_oh);
  assign o_div[0]  = 64'(a_div);  assign o_div[1]  = 64'(b_div);  assign o_div[2]  = 64'(c_div);
  assign o_busy[0] = 64'(a_busy); assign o_busy[1] = 64'(b_busy); assign o_busy[2] = 64'(c_busy);
  assign o_rv[0]   = 64'(a_rv);   assign o_rv[1]   = 64'(b_rv);   assign o_rv[2]   = 64'(c_rv);

  int n_checks = 0;
  int n_pass = 0;

  int nch [3] = '{3, 3, 5};
  int cw  [3] = '{15, 4, 8};
  int m_cnt [3][5];
  bit m_sat [3][5];
  bit m_counting = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 5; k++) begin
        m_cnt[i][k] = 0;
        m_sat[i][k] = 0;
      end
  endtask

  task automatic m_pix(input logic [4:0] en);
    if (!m_counting) return;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < nch[i]; k++)
        if (en[k]) begin
          if (m_cnt[i][k] == (1 << cw[i]) - 1) m_sat[i][k] = 1;
          else m_cnt[i][k]++;
        end
  endtask

  function automatic logic [63:0] exp_flat(input int i);
    logic [63:0] r = '0;
    for (int k = 0; k < nch[i]; k++) r |= 64'(m_cnt[i][k]) << (k * cw[i]);
    return r;
  endfunction

  function automatic logic [63:0] exp_satv(input int i);
    logic [63:0] r = '0;
    for (int k = 0; k < nch[i]; k++) r[k] = m_sat[i][k];
    return r;
  endfunction

  // Dominant = first channel holding the largest count.
  function automatic int exp_dom(input int i);
    int mx = 0;
    for (int k = 0; k < nch[i]; k++) if (m_cnt[i][k] > mx) mx = m_cnt[i][k];
    for (int k = 0; k < nch[i]; k++) if (m_cnt[i][k] == mx) return k;
    return 0;
  endfunction

  task automatic check_counts(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_i%0d_cnt", tag, i), o_flat[i], exp_flat(i));
      check($sformatf("%s_i%0d_sat", tag, i), o_sat[i], exp_satv(i));
    end
  endtask

  task automatic check_results(input string tag);
    int d;
    for (int i = 0; i < 3; i++) begin
      d = exp_dom(i);
      check($sformatf("%s_i%0d_rv", tag, i), o_rv[i], 64'd1);
      check($sformatf("%s_i%0d_dom", tag, i), o_dom[i], 64'(d));
      check($sformatf("%s_i%0d_onehot", tag, i), o_oh[i], 64'd1 << d);
      check($sformatf("%s_i%0d_div", tag, i), o_div[i], 64'(m_cnt[i][d]));
    end
  endtask

  task automatic send_start();
    frame_start = 1'b1;
    pix_valid   = 1'($urandom_range(0, 1));
    pix_ch_en   = 5'($urandom_range(0, 31));
    tick();
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    m_clear();
    m_counting = 1;
  endtask

  task automatic send_pix(input logic [4:0] en, input bit v);
    pix_valid = v;
    pix_ch_en = en;
    tick();
    if (v) m_pix(en);
    pix_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input logic [4:0] en, input bit wp);
    frame_end = 1'b1;
    pix_valid = wp;
    pix_ch_en = en;
    tick();
    if (wp) m_pix(en);
    m_counting = 0;
    frame_end = 1'b0;
    check({tag, "_busy_scan"}, o_busy[0], 64'd1);
    for (int e = 2; e <= 5; e++) begin
      pix_valid = 1'($urandom_range(0, 1));
      pix_ch_en = 5'($urandom_range(0, 31));
      frame_end = 1'($urandom_range(0, 1));
      tick();
      if (e == 2) check({tag, "_rv_early"}, o_rv[0], 64'd0);
      if (e == 3) begin
        check({tag, "_rv_a3"}, o_rv[0], 64'd1);
        check({tag, "_rv_b3"}, o_rv[1], 64'd1);
        check({tag, "_rv_c_early"}, o_rv[2], 64'd0);
        check({tag, "_busy_done"}, o_busy[0], 64'd0);
      end
      if (e == 5) check({tag, "_rv_c5"}, o_rv[2], 64'd1);
    end
    pix_valid = 1'b0;
    frame_end = 1'b0;
    check_counts(tag);
    check_results(tag);
  endtask

  task automatic repeat_pix(input logic [4:0] en, input int n);
    for (int j = 0; j < n; j++) send_pix(en, 1'b1);
  endtask

  initial begin
    m_clear();
    #2 reset = 1'b1;
    #1;
    check_counts("reset");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_i%0d_busy", i), o_busy[i], 64'd0);
      check($sformatf("reset_i%0d_rv", i), o_rv[i], 64'd0);
      check($sformatf("reset_i%0d_dom", i), o_dom[i], 64'd0);
      check($sformatf("reset_i%0d_oh", i), o_oh[i], 64'd0);
      check($sformatf("reset_i%0d_div", i), o_div[i], 64'd0);
    end
    tick();
    tick();
    reset = 1'b0;
    send_pix(5'b00111, 1'b1);
    check_counts("idle_ignore");

    // 5 R, 9 G, 2 B
    send_start();
    repeat_pix(5'b00001, 5);
    repeat_pix(5'b00010, 9);
    repeat_pix(5'b00100, 2);
    finish_frame("basic", 5'b00000, 1'b0);
    check("basic_dom", o_dom[0], 64'd1);
    check("basic_oh", o_oh[0], 64'b010);
    check("basic_div", o_div[0], 64'd9);

    send_start();
    repeat_pix(5'b00011, 7);
    repeat_pix(5'b00100, 3);
    finish_frame("tie_rg", 5'b00000, 1'b0);
    check("tie_rg_dom", o_dom[0], 64'd0);
    check("tie_rg_div", o_div[0], 64'd7);

    send_start();
    repeat_pix(5'b00110, 7);
    repeat_pix(5'b00001, 3);
    finish_frame("tie_gb", 5'b00000, 1'b0);
    check("tie_gb_dom", o_dom[0], 64'd1);

    send_start();
    repeat_pix(5'b00111, 20);
    finish_frame("sat", 5'b00000, 1'b0);
    check("sat_cnt", o_flat[1], 64'hfff);
    check("sat_flags", o_sat[1], 64'b111);
    check("sat_div", o_div[1], 64'd15);
    check("sat_dom", o_dom[1], 64'd0);

    send_start();
    repeat_pix(5'b00010, 2);
    finish_frame("end_pix", 5'b00100, 1'b1);
    check("end_pix_cnt", o_flat[0], {19'd0, 15'd1, 15'd2, 15'd0});

    // frame_start arriving during SCAN
    send_start();
    repeat_pix(5'b00101, 4);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    frame_start = 1'b1;
    pix_valid = 1'b1;
    pix_ch_en = 5'b11111;
    tick();
    frame_start = 1'b0;
    pix_valid = 1'b0;
    m_clear();
    m_counting = 1;
    check_counts("restart");
    check("restart_rv", o_rv[0], 64'd0);
    check("restart_busy", o_busy[2], 64'd1);
    repeat_pix(5'b01010, 3);
    finish_frame("restart", 5'b00000, 1'b0);

    // asynchronous reset mid-COUNT, observed between edges
    send_start();
    repeat_pix(5'b10111, 3);
    reset = 1'b1;
    #1;
    m_clear();
    m_counting = 0;
    check_counts("areset");
    check("areset_busy", o_busy[0], 64'd0);
    check("areset_rv", o_rv[2], 64'd0);
    check("areset_div", o_div[2], 64'd0);
    #1 reset = 1'b0;
    send_pix(5'b11111, 1'b1);
    check_counts("areset_idle");

    send_start();
    repeat_pix(5'b11111, 1);
    repeat_pix(5'b01110, 3);
    repeat_pix(5'b01000, 5);
    repeat_pix(5'b10000, 1);
    finish_frame("nch5", 5'b00000, 1'b0);
    check("nch5_dom", o_dom[2], 64'd3);
    check("nch5_div", o_div[2], 64'd9);

    for (int f = 0; f < 25; f++) begin
      int n;
      send_start();
      n = $urandom_range(0, 40);
      for (int j = 0; j < n; j++)
        send_pix(5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0));
      finish_frame($sformatf("rnd%0d", f), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
